rem_config_loader: RTL and testbench
====================================

// Module: rem_config_loader
// PURPOSE
//  Configuration writer for the regex character-match cell array. Accepts a pattern as a
//  byte stream and drives the per-cell config bus (config_valid, config_char, config_chained)
//  one cell per cycle. Pads unused cells, then reports length and overflow. Sits between the
//  host command path and the cell array. Holds the array's input path off while busy.
// PARAMETERS
//  NUM_CELLS  16     number of character-match cells in the array (>=2)
//  PAD_CHAR   8'h00  char written to unused cells (pattern bytes must not equal it)
//  IDX_W      $clog2(NUM_CELLS+1)  width of cell index / length
// PORTS
//  clk             in   1          single clock, all logic on posedge
//  rst_n           in   1          asynchronous, active-low reset
//  start           in   1          begin loading a new pattern (honoured only in IDLE)
//  in_valid        in   1          pattern byte valid
//  in_data         in   8          pattern byte
//  in_last         in   1          final byte of the pattern
//  in_ready        out  1          byte accepted when in_valid & in_ready
//  cfg_valid       out  NUM_CELLS  one-hot write strobe, bit i = cell i
//  cfg_char        out  8          char for the strobed cell
//  cfg_chained     out  1          chained flag for the strobed cell
//  busy            out  1          load in progress; array input_valid must be gated low
//  done            out  1          one-cycle pulse when load and padding complete
//  pat_len         out  IDX_W      cells written with pattern bytes, valid from done
//  overflow        out  1          sticky: pattern longer than NUM_CELLS
// BEHAVIOUR
//  - Reset: state IDLE; cfg_valid=0, cfg_char=0, cfg_chained=0, in_ready=0, busy=0, done=0,
//    pat_len=0, overflow=0, index=0. Every output is a register, so latency is 1 cycle.
//  - IDLE: in_ready=0. When start=1, go to LOAD, clear index, pat_len and overflow, and set busy=1.
//  - LOAD: in_ready=1. For each accepted byte with index<NUM_CELLS, the next cycle drives:
//    cfg_valid[index]=1, cfg_char=in_data, cfg_chained=0 for the first cell of a term and 1
//    otherwise. Then index++ and pat_len++.
//  - Accepted byte with index==NUM_CELLS: no write, overflow<=1; the rest of the stream is
//    still consumed up to in_last.
//  - Accepted in_last: if index<NUM_CELLS go to PAD, else go to DONE. The write for the
//    last byte itself still occurs.
//  - PAD: in_ready=0. Write cells index..NUM_CELLS-1 one per cycle, each with
//    cfg_char=PAD_CHAR and cfg_chained=1. After cell NUM_CELLS-1 go to DONE.
//  - DONE: one cycle. done=1, busy<=0, then go to IDLE. pat_len and overflow hold until
//    the next start.
//  - At most one cfg_valid bit is set in any cycle. cfg_valid is all zero when no write occurs.
//  - start outside IDLE is ignored. in_valid with in_ready=0 is not consumed.
//  - An empty pattern is impossible: in_last always accompanies at least one byte.
//  - rst_n asserted mid-load: outputs return to reset values immediately. Cells already
//    written are not cleared; the host must reload them.
// CONFIGURATION
//  REM_CFG_ALT_EN defined:
//   - In LOAD, byte 8'h7C ('|') is consumed without a write and marks a term boundary.
//   - The next written cell gets cfg_chained=0, so the array can match alternatives.
//   - Consecutive or leading '|' bytes collapse into a single boundary.
//   - A trailing '|' before in_last writes nothing.
//  REM_CFG_ALT_EN undefined:
//   - 8'h7C is an ordinary literal.
//   - Only cell 0 is written with cfg_chained=0.
// TESTING
//  T1 NUM_CELLS=4, start, "ab"+last -> cfg_valid 0001/'a'/ch0, then 0010/'b'/ch1,
//     then 0100 and 1000 with PAD_CHAR/ch1; done pulse, pat_len=2, overflow=0.
//  T2 "abcdef" into 4 cells -> writes a,b,c,d only; e,f consumed without writes; no PAD;
//     done, pat_len=4, overflow=1.
//  T3 in_valid toggled 1/0 each cycle for "abc" -> exactly 3 pattern writes in order;
//     no write on idle cycles; start asserted mid-LOAD has no effect.
//  T4 rst_n low during PAD after "a" -> all outputs 0 at once; after release, start and
//     "xy" -> normal load, overflow=0.
//  T5 (REM_CFG_ALT_EN) "ab|c" -> cells a/ch0, b/ch1, c/ch0, pad/ch1; pat_len=3.
//     Without the macro -> a/ch0, b/ch1, '|'/ch1, c/ch1; pat_len=4.
//  T6 single byte "z"+last with NUM_CELLS=2 -> cell0 'z'/ch0, cell1 pad/ch1; busy high
//     from the cycle after start through done; done high exactly 1 cycle.

Source files
------------

// File: rtl/rem_config_loader.sv
// rtl/rem_config_loader.sv - byte-stream pattern loader for the regex character-match cell array
//
// Purpose:
//   Takes a pattern as a byte stream and writes it into the character-match cell array,
//   one cell per cycle. Cells beyond the pattern are padded with PAD_CHAR. At the end a
//   one-cycle done pulse is issued, with the pattern length and a sticky overflow flag.
//   All outputs are registered: a write for a byte accepted on edge N appears after edge N.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a new load (only honoured while idle)
//   in_valid/in_data/in_last   pattern byte stream, consumed when in_valid & in_ready
//   in_ready                   high while a pattern is being accepted
//   cfg_valid[NUM_CELLS]       one-hot cell write strobe
//   cfg_char, cfg_chained      character and chained flag for the strobed cell
//   busy                       load in progress (array input must be gated)
//   done                       one-cycle completion pulse
//   pat_len, overflow          pattern cell count and sticky too-long flag
//
// Optional feature (macro REM_CFG_ALT_EN):
//   8'h7C ('|') becomes a term separator; the next written cell starts a new term
//   (cfg_chained=0). Without the macro, '|' is a plain literal.
module rem_config_loader #(
    parameter int         NUM_CELLS = 16,
    parameter logic [7:0] PAD_CHAR  = 8'h00,
    parameter int         IDX_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [NUM_CELLS-1:0] cfg_valid,
    output logic [7:0]           cfg_char,
    output logic                 cfg_chained,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     pat_len,
    output logic                 overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;

    localparam logic [IDX_W-1:0] CELLS     = IDX_W'(NUM_CELLS);
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(NUM_CELLS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [IDX_W-1:0]       pat_len_q, pat_len_d;
    logic                   overflow_q, overflow_d;
    logic                   first_q, first_d;
    logic [NUM_CELLS-1:0]   cfg_valid_q, cfg_valid_d;
    logic [7:0]             cfg_char_q, cfg_char_d;
    logic                   cfg_chained_q, cfg_chained_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   is_sep;
    logic                   room;
    logic                   wr_byte;
    logic [IDX_W-1:0]       idx_after;

    assign accept = in_valid & in_ready_q;

`ifdef REM_CFG_ALT_EN
    assign is_sep = (in_data == 8'h7C);
`else
    assign is_sep = 1'b0;
`endif

    assign room      = (index_q < CELLS);
    assign wr_byte   = accept & ~is_sep & room;
    // Index after this cycle's byte; decides whether padding is still needed.
    assign idx_after = index_q + IDX_W'(wr_byte);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            index_q       <= '0;
            pat_len_q     <= '0;
            overflow_q    <= 1'b0;
            first_q       <= 1'b1;
            cfg_valid_q   <= '0;
            cfg_char_q    <= 8'h00;
            cfg_chained_q <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            pat_len_q     <= pat_len_d;
            overflow_q    <= overflow_d;
            first_q       <= first_d;
            cfg_valid_q   <= cfg_valid_d;
            cfg_char_q    <= cfg_char_d;
            cfg_chained_q <= cfg_chained_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (accept && in_last) begin
                    state_d = (idx_after < CELLS) ? S_PAD : S_DONE;
                end
            end
            S_PAD:  if (index_q == LAST_CELL) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        index_d       = index_q;
        pat_len_d     = pat_len_q;
        overflow_d    = overflow_q;
        first_d       = first_q;
        cfg_valid_d   = '0;
        cfg_char_d    = 8'h00;
        cfg_chained_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d    = '0;
                    pat_len_d  = '0;
                    overflow_d = 1'b0;
                    first_d    = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (is_sep) begin
                        // Separators only mark the boundary; repeats collapse naturally.
                        first_d = 1'b1;
                    end else if (room) begin
                        cfg_valid_d   = NUM_CELLS'(1) << index_q;
                        cfg_char_d    = in_data;
                        cfg_chained_d = ~first_q;
                        first_d       = 1'b0;
                        index_d       = idx_after;
                        pat_len_d     = pat_len_q + IDX_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            S_PAD: begin
                cfg_valid_d   = NUM_CELLS'(1) << index_q;
                cfg_char_d    = PAD_CHAR;
                cfg_chained_d = 1'b1;
                index_d       = index_q + IDX_W'(1);
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
        // Ready tracks the state the stream handshake will be evaluated in.
        in_ready_d = (state_d == S_LOAD);
        // Busy covers LOAD/PAD/DONE so it stays high through the done pulse.
        busy_d     = (state_q != S_IDLE) | start;
        done_d     = (state_q == S_DONE);
    end

    assign in_ready    = in_ready_q;
    assign cfg_valid   = cfg_valid_q;
    assign cfg_char    = cfg_char_q;
    assign cfg_chained = cfg_chained_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pat_len     = pat_len_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_rem_config_loader.sv
// tb/tb_rem_config_loader.sv - self-checking bench for rem_config_loader
module tb_rem_config_loader;

`ifdef REM_CFG_ALT_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif
    localparam int         N   = 4;
    localparam logic [7:0] PAD = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, in_last;
    logic [7:0] in_data;
    logic       in_ready, cfg_chained, busy, done, overflow;
    logic [3:0] cfg_valid;
    logic [7:0] cfg_char;
    logic [2:0] pat_len;

    logic       start2, in_valid2, in_last2;
    logic [7:0] in_data2;
    logic       in_ready2, cfg_chained2, busy2, done2, overflow2;
    logic [1:0] cfg_valid2;
    logic [7:0] cfg_char2;
    logic [1:0] pat_len2;

    always #5 clk = ~clk;

    rem_config_loader #(.NUM_CELLS(N), .PAD_CHAR(PAD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .cfg_valid(cfg_valid), .cfg_char(cfg_char),
        .cfg_chained(cfg_chained), .busy(busy), .done(done), .pat_len(pat_len),
        .overflow(overflow)
    );

    rem_config_loader #(.NUM_CELLS(2), .PAD_CHAR(PAD)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
        .in_last(in_last2), .in_ready(in_ready2), .cfg_valid(cfg_valid2), .cfg_char(cfg_char2),
        .cfg_chained(cfg_chained2), .busy(busy2), .done(done2), .pat_len(pat_len2),
        .overflow(overflow2)
    );

    typedef struct packed {
        logic [3:0] v;
        logic [7:0] c;
        logic       ch;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  got_e;
    int   exp_len;
    bit   exp_ovf;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the cell image a pattern must produce, derived directly from the pattern text.
    task automatic build_model(input string s, input int n);
        int  idx;
        bit  first;
        byte c;
        wr_t w;
        idx = 0;
        first = 1'b1;
        exp_q.delete();
        exp_len = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (ALT && c == 8'h7C) begin
                first = 1'b1;
            end else if (idx < n) begin
                w.v  = 4'b0001 << idx;
                w.c  = c;
                w.ch = !first;
                exp_q.push_back(w);
                first = 1'b0;
                idx++;
                exp_len++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        for (int j = idx; j < n; j++) begin
            w.v  = 4'b0001 << j;
            w.c  = PAD;
            w.ch = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    // Per-cycle comparison of the N=4 instance against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_valid !== 4'b0000) begin
                chk("cfg_onehot", 32'($onehot(cfg_valid)), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(cfg_valid), 0);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("cfg_valid", 32'(cfg_valid), 32'(got_e.v));
                    chk("cfg_char", 32'(cfg_char), 32'(got_e.c));
                    chk("cfg_chained", 32'(cfg_chained), 32'(got_e.ch));
                end
            end
            if (done === 1'b1) begin
                chk("pat_len", 32'(pat_len), 32'(exp_len));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                chk("writes_left", 32'(exp_q.size()), 0);
                chk("busy_at_done", 32'(busy), 1);
            end
        end
    end

    task automatic send(input string s, input bit gaps, input bit early);
        int   tmo;
        logic ok;
        start = 1'b1;
        if (early) begin
            in_valid = 1'b1;
            in_data  = s[0];
            in_last  = (s.len() == 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = (i == s.len() - 1);
            tmo = 0;
            ok  = 1'b0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                tmo++;
            end while (!ok && tmo < 50);
            if (!ok) chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (gaps && i != s.len() - 1) begin
                in_data = 8'hEE;
                if (i == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            n++;
        end
        chk("done_seen", 32'(seen), 1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        start2 = 1'b0; in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_valid", 32'(cfg_valid), 0);
        chk("rst_cfg_char", 32'(cfg_char), 0);
        chk("rst_cfg_chained", 32'(cfg_chained), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pat_len", 32'(pat_len), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 0);

        // T1: "ab" into 4 cells
        build_model("ab", N);
        chk("t1_model_size", 32'(exp_q.size()), 4);
        chk("t1_model_w0", 32'(exp_q[0]), 32'({4'b0001, 8'h61, 1'b0}));
        chk("t1_model_w1", 32'(exp_q[1]), 32'({4'b0010, 8'h62, 1'b1}));
        chk("t1_model_w3", 32'(exp_q[3]), 32'({4'b1000, 8'h00, 1'b1}));
        send("ab", 1'b0, 1'b0);
        wait_done();
        chk("t1_pat_len", 32'(pat_len), 2);
        chk("t1_overflow", 32'(overflow), 0);

        // T2: overflow
        build_model("abcdef", N);
        chk("t2_model_size", 32'(exp_q.size()), 4);
        chk("t2_model_ovf", 32'(exp_ovf), 1);
        send("abcdef", 1'b0, 1'b0);
        wait_done();
        chk("t2_pat_len", 32'(pat_len), 4);
        chk("t2_overflow", 32'(overflow), 1);

        // T3: gapped stream, byte offered during start, start mid-load
        build_model("abc", N);
        send("abc", 1'b1, 1'b1);
        wait_done();
        chk("t3_pat_len", 32'(pat_len), 3);
        chk("t3_overflow", 32'(overflow), 0);

        // T4: reset during padding, then a clean reload
        build_model("a", N);
        send("a", 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("t4_in_pad", 32'(cfg_valid), 32'(4'b0010));
        rst_n = 1'b0;
        #1;
        chk("t4_rst_cfg_valid", 32'(cfg_valid), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_cfg_char", 32'(cfg_char), 0);
        chk("t4_rst_chained", 32'(cfg_chained), 0);
        chk("t4_rst_pat_len", 32'(pat_len), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        build_model("xy", N);
        send("xy", 1'b0, 1'b0);
        wait_done();
        chk("t4_pat_len", 32'(pat_len), 2);
        chk("t4_overflow", 32'(overflow), 0);

        // T5: separator handling
        build_model("ab|c", N);
`ifdef REM_CFG_ALT_EN
        chk("t5_model_w2", 32'(exp_q[2]), 32'({4'b0100, 8'h63, 1'b0}));
        chk("t5_model_len", 32'(exp_len), 3);
`else
        chk("t5_model_w2", 32'(exp_q[2]), 32'({4'b0100, 8'h7C, 1'b1}));
        chk("t5_model_len", 32'(exp_len), 4);
`endif
        send("ab|c", 1'b0, 1'b0);
        wait_done();

        // Leading, repeated and trailing separators
        build_model("|a||b|", N);
        send("|a||b|", 1'b0, 1'b0);
        wait_done();

        // T6: single byte into a 2-cell array, cycle-exact
        start2 = 1'b1; in_valid2 = 1'b1; in_data2 = "z"; in_last2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("t6_c1_busy", 32'(busy2), 1);
        chk("t6_c1_ready", 32'(in_ready2), 1);
        chk("t6_c1_valid", 32'(cfg_valid2), 0);
        @(posedge clk); #1;
        in_valid2 = 1'b0; in_last2 = 1'b0;
        chk("t6_c2_valid", 32'(cfg_valid2), 32'(2'b01));
        chk("t6_c2_char", 32'(cfg_char2), 32'(8'h7A));
        chk("t6_c2_chained", 32'(cfg_chained2), 0);
        chk("t6_c2_ready", 32'(in_ready2), 0);
        @(posedge clk); #1;
        chk("t6_c3_valid", 32'(cfg_valid2), 32'(2'b10));
        chk("t6_c3_char", 32'(cfg_char2), 0);
        chk("t6_c3_chained", 32'(cfg_chained2), 1);
        chk("t6_c3_busy", 32'(busy2), 1);
        chk("t6_c3_done", 32'(done2), 0);
        @(posedge clk); #1;
        chk("t6_c4_valid", 32'(cfg_valid2), 0);
        chk("t6_c4_done", 32'(done2), 1);
        chk("t6_c4_busy", 32'(busy2), 1);
        chk("t6_c4_pat_len", 32'(pat_len2), 1);
        chk("t6_c4_overflow", 32'(overflow2), 0);
        @(posedge clk); #1;
        chk("t6_c5_done", 32'(done2), 0);
        chk("t6_c5_busy", 32'(busy2), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
